// File: rtl/i2c_ebr_write_sequencer_pkg.sv
// Shared definitions for the I2C EBR write sequencer: FSM encoding and EBR geometry.
package i2c_ebr_write_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned EBR_DEPTH  = 512;
  localparam int unsigned EBR_ADDR_W = 9;

endpackage

// File: rtl/i2c_ebr_write_sequencer_sync_pulse.sv
// sync_pulse: STAGES-flop synchronizer followed by a rising-edge detector that emits a
// single-cycle pulse in the destination clock domain.
module sync_pulse #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic [STAGES-1:0] chain;
  logic              last;

  always_ff @(posedge clock) begin
    if (reset) begin
      chain <= '0;
      last  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      last  <= chain[STAGES-1];
    end
  end

  assign pulse = chain[STAGES-1] & ~last;

endmodule

// File: rtl/i2c_ebr_write_sequencer.sv
// Brings the SCL-timed byte strobes into the system clock domain and sequences writes into
// two 512x8 EBRs. Optional running checksum: define EBR_WRITE_SEQUENCER_CHECKSUM_EN.
module i2c_ebr_write_sequencer
  import i2c_ebr_write_sequencer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEPTH        = EBR_DEPTH,
  parameter int unsigned IDLE_TIMEOUT = 65535
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ebr_select,
  input  logic                     ebr_wren,
  input  logic [7:0]               ebr_data_in,
  output logic [$clog2(DEPTH)-1:0] wr_addr,
  output logic [7:0]               wr_data,
  output logic [1:0]               wr_en,
  output logic [1:0]               loaded,
  output logic                     overflow,
  output logic                     busy
`ifdef EBR_WRITE_SEQUENCER_CHECKSUM_EN
  ,
  output logic [7:0]               checksum,
  output logic                     checksum_valid
`endif
);

  localparam int unsigned       AW        = $clog2(DEPTH);
  localparam logic [AW-1:0]     LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [15:0]       TMO_LIMIT = 16'(IDLE_TIMEOUT - 1);

  state_t        state, state_d;
  logic          evt;
  logic          sel;
  logic [AW-1:0] addr_next;
  logic [15:0]   tmo_cnt;
  logic          timeout;
  logic          new_sel;
  logic          do_write, restart, set_over, set_load, clr_load;

  sync_pulse #(.STAGES(SYNC_STAGES)) u_wren_sync (
    .clock (clock),
    .reset (reset),
    .d     (ebr_wren),
    .pulse (evt)
  );

  assign new_sel = (ebr_select != sel);
  assign timeout = (tmo_cnt >= TMO_LIMIT);
  assign busy    = (state == ST_FILL);

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  // A byte event always takes priority over an expiring timeout.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (evt) state_d = ST_FILL;
      ST_FILL: begin
        if (evt) begin
          if (!new_sel && addr_next == LAST_ADDR) state_d = ST_DONE;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (evt) begin
          if (new_sel) state_d = ST_FILL;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    do_write = 1'b0;
    restart  = 1'b0;
    set_over = 1'b0;
    set_load = 1'b0;
    clr_load = 1'b0;
    case (state)
      ST_IDLE: if (evt) begin
        do_write = 1'b1;
        restart  = 1'b1;
      end
      ST_FILL: if (evt) begin
        do_write = 1'b1;
        if (new_sel) begin
          restart  = 1'b1;
          clr_load = 1'b1;
        end else if (addr_next == LAST_ADDR) begin
          set_load = 1'b1;
        end
      end
      ST_DONE: if (evt) begin
        if (new_sel) begin
          do_write = 1'b1;
          restart  = 1'b1;
        end else begin
          set_over = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_en     <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      addr_next <= '0;
      sel       <= 1'b0;
      loaded    <= '0;
      overflow  <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      wr_en <= '0;
      if (do_write) begin
        wr_en     <= ebr_select ? 2'b10 : 2'b01;
        wr_addr   <= restart ? '0 : addr_next;
        wr_data   <= ebr_data_in;
        addr_next <= restart ? AW'(1) : addr_next + 1'b1;
      end
      if (restart)  sel                <= ebr_select;
      if (clr_load) loaded[ebr_select] <= 1'b0;
      if (set_load) loaded[sel]        <= 1'b1;
      if (set_over) overflow           <= 1'b1;
      if (evt || state_d == ST_IDLE) tmo_cnt <= '0;
      else if (tmo_cnt != '1)         tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

`ifdef EBR_WRITE_SEQUENCER_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      checksum       <= '0;
      checksum_valid <= 1'b0;
    end else begin
      if (do_write) checksum <= restart ? ebr_data_in : checksum + ebr_data_in;
      checksum_valid <= (state_d == ST_DONE) && (state != ST_DONE);
    end
  end
`endif

endmodule

// File: tb/tb_i2c_ebr_write_sequencer.sv
// Randomized scoreboard bench for i2c_ebr_write_sequencer against a fill-level reference model.
module tb_i2c_ebr_write_sequencer;

  localparam int unsigned SYNC  = 2;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned TMO   = 300;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ebr_select = 1'b0;
  logic       ebr_wren = 1'b0;
  logic [7:0] ebr_data_in = '0;
  logic [8:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] wr_en, loaded;
  logic       overflow, busy;
`ifdef EBR_WRITE_SEQUENCER_CHECKSUM_EN
  logic [7:0] checksum;
  logic       checksum_valid;
  int         cs_pulses = 0;
`endif

  i2c_ebr_write_sequencer #(
    .SYNC_STAGES  (SYNC),
    .DEPTH        (DEPTH),
    .IDLE_TIMEOUT (TMO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ebr_select  (ebr_select),
    .ebr_wren    (ebr_wren),
    .ebr_data_in (ebr_data_in),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .loaded      (loaded),
    .overflow    (overflow),
    .busy        (busy)
`ifdef EBR_WRITE_SEQUENCER_CHECKSUM_EN
    ,
    .checksum       (checksum),
    .checksum_valid (checksum_valid)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] en;
    logic [8:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  // Reference model: one fill at a time, tracked as a byte count against DEPTH.
  bit         m_active, m_full, m_sel, m_over;
  int         m_count;
  bit   [1:0] m_loaded;
  logic [7:0] m_sum;
  int         m_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_full = 0; m_sel = 0; m_over = 0;
    m_count = 0; m_loaded = '0; m_sum = '0;
  endtask

  task automatic model_byte(input bit sel, input logic [7:0] d, output bit wrote);
    wr_t w;
    wrote = 0;
    if (!m_active) begin
      m_active = 1; m_full = 0; m_sel = sel; m_count = 0; m_sum = '0;
    end else if (sel != m_sel) begin
      if (!m_full) m_loaded[sel] = 0;
      m_full = 0; m_sel = sel; m_count = 0; m_sum = '0;
    end else if (m_full) begin
      m_over = 1;
      return;
    end
    w.en   = sel ? 2'b10 : 2'b01;
    w.addr = 9'(m_count);
    w.data = d;
    exp_q.push_back(w);
    wrote = 1;
    m_sum = m_sum + d;
    m_count++;
    if (m_count == DEPTH) begin
      m_full = 1;
      m_loaded[sel] = 1;
      m_done++;
    end
  endtask

  // One SCL period of 8 clocks: wren high for 4, low for 4; data/select held until the next byte.
  task automatic send_byte(input bit sel, input logic [7:0] d);
    bit wrote;
    bit seen = 0;
    int lat = 0;
    ebr_select  = sel;
    ebr_data_in = d;
    ebr_wren    = 1'b1;
    model_byte(sel, d, wrote);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clock); #1;
      if (!seen && wr_en != 2'b00) begin
        seen = 1;
        lat  = c;
      end
      if (c == 4) ebr_wren = 1'b0;
    end
    if (wrote) check("latency", lat, SYNC + 1);
    else       check("no_write", {31'd0, seen}, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
    if (n > int'(TMO)) m_active = 0;
  endtask

  task automatic do_reset();
    check("pending_before_reset", exp_q.size(), 0);
    exp_q.delete();
    reset = 1'b1;
    ebr_wren = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_loaded", loaded, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_loaded"}, loaded, m_loaded);
    check({tag, "_overflow"}, overflow, m_over);
    check({tag, "_busy"}, busy, m_active && !m_full);
  endtask

  always @(negedge clock) begin
    if (!reset && wr_en != 2'b00) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", wr_en, 0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_en", wr_en, e.en);
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
      end
    end
  end

`ifdef EBR_WRITE_SEQUENCER_CHECKSUM_EN
  always @(negedge clock) begin
    if (!reset && checksum_valid) begin
      cs_pulses++;
      check("checksum", checksum, m_sum);
    end
  end
`endif

  initial begin
    bit rsel = 0;
    model_reset();
    do_reset();

    send_byte(0, 8'hA5);
    send_byte(0, 8'h3C);
    send_byte(0, 8'hFF);
    check_status("three_bytes");
    idle(TMO + 100);
    check_status("after_timeout");

    for (int i = 0; i < 512; i++) send_byte(1, 8'(i % 256));
    check_status("full_fill");
    check("full_loaded_const", loaded, 2'b10);

    send_byte(1, 8'h5A);
    check_status("overflow");
    send_byte(1, 8'($urandom));
    check("overflow_sticky", overflow, 1);
    idle(TMO + 100);
    check("overflow_after_idle", overflow, 1);

    for (int i = 0; i < 10; i++) send_byte(0, 8'($urandom));
    idle(TMO + 1);
    send_byte(0, 8'h77);
    check_status("timeout_restart");

    for (int i = 0; i < 100; i++) send_byte(0, 8'($urandom));
    send_byte(1, 8'h11);
    check_status("switch_sel");

    for (int i = 0; i < 199; i++) send_byte(1, 8'($urandom));
    do_reset();
    send_byte(0, 8'h42);
    check_status("after_midfill_reset");

`ifdef EBR_WRITE_SEQUENCER_CHECKSUM_EN
    do_reset();
    for (int i = 0; i < 512; i++) send_byte(0, 8'h01);
    check_status("checksum_fill");
`endif

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) rsel = ~rsel;
      if ($urandom_range(0, 63) == 0) idle(TMO + 10);
      send_byte(rsel, 8'($urandom));
    end
    check_status("random");

    idle(20);
    check("queue_drained", exp_q.size(), 0);
`ifdef EBR_WRITE_SEQUENCER_CHECKSUM_EN
    check("checksum_pulses", cs_pulses, m_done);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
